prog_ctrl: RTL

Program and run-control sequencer for the 4-bit CPU core. It holds the 16×8 instruction memory and supplies `opecode`/`imm` from the CPU's `addr`. It accepts program bytes from a host over a valid/ready load port and drives the CPU's reset and per-instruction clock enable, supporting run, halt, single-step and one address breakpoint. It sits between the host/debug interface and the CPU instance in the board top.

---
 rtl/prog_ctrl_pkg.sv | 16 +
 rtl/prog_mem.sv | 27 ++
 rtl/prog_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/prog_ctrl_pkg.sv
// Shared types and sizes for the program/run-control sequencer.
// The host loads a 16-entry program and then runs, steps or halts the CPU.
package prog_ctrl_pkg;

   localparam int ADDR_W    = 4;
   localparam int INSTR_W   = 8;
   localparam int MEM_DEPTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      STEP = 2'd3
   } state_t;

endpackage

// File: rtl/prog_mem.sv
// 16x8 instruction store: synchronous write, asynchronous read, cleared on reset.
import prog_ctrl_pkg::*;

module prog_mem (
   input  logic               clk,
   input  logic               rst,
   input  logic               we,
   input  logic [ADDR_W-1:0]  waddr,
   input  logic [INSTR_W-1:0] wdata,
   input  logic [ADDR_W-1:0]  raddr,
   output logic [INSTR_W-1:0] rdata
);

   logic [INSTR_W-1:0] mem [MEM_DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read is combinational so the CPU sees the new instruction the cycle addr moves.
   assign rdata = mem[raddr];

endmodule

// File: rtl/prog_ctrl.sv
// Program load and run-control sequencer for the 4-bit CPU: owns the program
// memory, gates the CPU clock enable for run/step and stops on a breakpoint.
import prog_ctrl_pkg::*;

module prog_ctrl #(
   parameter int RUN_PERIOD = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ld_start,
   input  logic               ld_valid,
   output logic               ld_ready,
   input  logic [INSTR_W-1:0] ld_data,
   input  logic               run,
   input  logic               halt,
   input  logic               step,
   input  logic               bp_en,
   input  logic [ADDR_W-1:0]  bp_addr,
   input  logic [ADDR_W-1:0]  addr,
   output logic [3:0]         opecode,
   output logic [3:0]         imm,
   output logic               cpu_ce,
   output logic               cpu_n_rst,
   output logic               busy,
   output logic               bp_hit,
   output logic [7:0]         instr_count
);

   localparam logic [7:0]        DIV_LAST  = 8'(RUN_PERIOD - 1);
   localparam logic [ADDR_W-1:0] WPTR_LAST = ADDR_W'(MEM_DEPTH - 1);

   state_t             state;
   logic [ADDR_W-1:0]  wptr;
   logic [7:0]         div;
   logic               first;
   logic               accept;
   logic               slot;
   logic               bp_match;
   logic [INSTR_W-1:0] rdata;

   assign accept   = ld_valid && ld_ready;
   assign slot     = (div == DIV_LAST);
   // The instruction that stopped us is allowed to execute on the next run.
   assign bp_match = bp_en && (addr == bp_addr) && !first;

   assign cpu_n_rst = !(rst || state == LOAD);
   assign opecode   = rdata[7:4];
   assign imm       = rdata[3:0];

   prog_mem u_mem (
      .clk   (clk),
      .rst   (rst),
      .we    (accept),
      .waddr (wptr),
      .wdata (ld_data),
      .raddr (addr),
      .rdata (rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         wptr        <= '0;
         div         <= '0;
         first       <= 1'b0;
         cpu_ce      <= 1'b0;
         ld_ready    <= 1'b0;
         busy        <= 1'b0;
         bp_hit      <= 1'b0;
         instr_count <= '0;
      end else begin
         cpu_ce <= 1'b0;
         if (cpu_ce) instr_count <= instr_count + 8'd1;

         case (state)
            IDLE: begin
               if (ld_start) begin
                  state       <= LOAD;
                  wptr        <= '0;
                  instr_count <= '0;
                  bp_hit      <= 1'b0;
                  ld_ready    <= 1'b1;
                  busy        <= 1'b1;
               end else if (run) begin
                  state  <= RUN;
                  div    <= '0;
                  bp_hit <= 1'b0;
                  first  <= 1'b1;
                  busy   <= 1'b1;
               end else if (step) begin
                  state  <= STEP;
                  cpu_ce <= 1'b1;
                  bp_hit <= 1'b0;
                  busy   <= 1'b1;
               end
            end

            LOAD: begin
               if (accept) begin
                  wptr <= wptr + 1'b1;
                  if (wptr == WPTR_LAST) begin
                     state    <= IDLE;
                     ld_ready <= 1'b0;
                     busy     <= 1'b0;
                  end
               end
            end

            RUN: begin
               if (halt) begin
                  state <= IDLE;
                  div   <= '0;
                  busy  <= 1'b0;
               end else if (slot) begin
                  div <= '0;
                  if (bp_match) begin
                     bp_hit <= 1'b1;
                     state  <= IDLE;
                     busy   <= 1'b0;
                  end else begin
                     cpu_ce <= 1'b1;
                     first  <= 1'b0;
                  end
               end else begin
                  div <= div + 8'd1;
               end
            end

            STEP: begin
               state <= IDLE;
               busy  <= 1'b0;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
